// File: rtl/qspi_flash_rom_responder.sv
// QSPI flash emulator: answers Quad I/O Fast Read (0xEB) with continuous-read
// mode from a synchronous ROM port. The SPI pins are oversampled on clk.
module qspi_flash_rom_responder #(
  parameter int         ADDR_BITS     = 24,
  parameter int         MEM_ADDR_BITS = 20,
  parameter int         DUMMY_CYCLES  = 4,
  parameter logic [7:0] READ_CMD      = 8'hEB
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_clk,
  input  logic                     spi_select,
  input  logic [3:0]               spi_data_in,
  output logic [3:0]               spi_data_out,
  output logic [3:0]               spi_data_oe,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_rd,
  input  logic [7:0]               mem_data,
  output logic                     busy,
  output logic                     cmd_error
);

  localparam logic [7:0]           ADDR_NIBS = 8'(ADDR_BITS / 4);
  localparam logic [7:0]           DUMMY_N   = 8'(DUMMY_CYCLES);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  // synchronizer stages plus a delayed copy for edge detection
  logic       sck_s1_q, sck_s2_q, sck_d_q;
  logic       cs_s1_q, cs_s2_q, cs_d_q;
  logic [3:0] sd_s1_q, sd_s2_q;
  logic       sck_rise, sck_fall;

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]     sr_q, sr_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [3:0]               mode_hi_q, mode_hi_d;
  logic                     cont_q, cont_d;
  logic [7:0]               byte_q, byte_d;
  logic [3:0]               lo_q, lo_d;
  logic                     lo_next_q, lo_next_d;
  logic                     lat_q, lat_d;
  logic [3:0]               dout_q, dout_d;
  logic [3:0]               oe_q, oe_d;
  logic                     busy_q, busy_d;
  logic                     rd_q, rd_d;
  logic                     err_q, err_d;
  logic [MEM_ADDR_BITS-1:0] maddr_q, maddr_d;

  logic [ADDR_BITS-1:0]     addr_nx, addr_inc;
  logic [7:0]               op_nx;
  logic                     drive_hi;

  // two-flop synchronizers on every SPI input; CS# idles deselected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s1_q <= 1'b0; sck_s2_q <= 1'b0; sck_d_q <= 1'b0;
      cs_s1_q  <= 1'b1; cs_s2_q  <= 1'b1; cs_d_q  <= 1'b1;
      sd_s1_q  <= 4'h0; sd_s2_q  <= 4'h0;
    end else begin
      sck_s1_q <= spi_clk;    sck_s2_q <= sck_s1_q; sck_d_q <= sck_s2_q;
      cs_s1_q  <= spi_select; cs_s2_q  <= cs_s1_q;  cs_d_q  <= cs_s2_q;
      sd_s1_q  <= spi_data_in; sd_s2_q <= sd_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_d_q;
  assign sck_fall = ~sck_s2_q & sck_d_q;

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'h00;
      sr_q      <= '0;
      addr_q    <= '0;
      mode_hi_q <= 4'h0;
      cont_q    <= 1'b0;
      byte_q    <= 8'h00;
      lo_q      <= 4'h0;
      lo_next_q <= 1'b0;
      lat_q     <= 1'b0;
      dout_q    <= 4'h0;
      oe_q      <= 4'h0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      maddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      addr_q    <= addr_d;
      mode_hi_q <= mode_hi_d;
      cont_q    <= cont_d;
      byte_q    <= byte_d;
      lo_q      <= lo_d;
      lo_next_q <= lo_next_d;
      lat_q     <= lat_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      maddr_q   <= maddr_d;
    end
  end

  // next-state: protocol decode on SCK rises, output driving on SCK falls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    mode_hi_d = mode_hi_q;
    cont_d    = cont_q;
    // ROM data is valid the cycle after the strobe; capture it then
    byte_d    = lat_q ? mem_data : byte_q;
    lat_d     = rd_q;
    lo_d      = lo_q;
    lo_next_d = lo_next_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    maddr_d   = maddr_q;
    rd_d      = 1'b0;
    err_d     = 1'b0;
    drive_hi  = 1'b0;
    addr_nx   = {sr_q[ADDR_BITS-5:0], sd_s2_q};
    op_nx     = {sr_q[6:0], sd_s2_q[0]};
    addr_inc  = addr_q + ADDR_ONE;

    if (state_q != S_IDLE && cs_s2_q) begin
      // deselect aborts anything in flight; cont survives for the next one
      state_d = S_IDLE;
      oe_d    = 4'h0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!cs_s2_q && cs_d_q) begin
            busy_d  = 1'b1;
            cnt_d   = 8'h00;
            state_d = cont_q ? S_ADDR : S_CMD;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sr_d  = {sr_q[ADDR_BITS-2:0], sd_s2_q[0]};
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd7) begin
              cnt_d = 8'h00;
              if (op_nx == READ_CMD) begin
                state_d = S_ADDR;
              end else begin
                err_d   = 1'b1;
                cont_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sr_d  = addr_nx;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == ADDR_NIBS - 8'd1) begin
              // first byte is fetched while mode and dummy clocks go by
              addr_d  = addr_nx;
              maddr_d = addr_nx[MEM_ADDR_BITS-1:0];
              rd_d    = 1'b1;
              cnt_d   = 8'h00;
              state_d = S_MODE;
            end
          end
        end
        S_MODE: begin
          if (sck_rise) begin
            if (cnt_q == 8'h00) begin
              mode_hi_d = sd_s2_q;
              cnt_d     = 8'd1;
            end else begin
              cont_d  = (mode_hi_q == 4'hA);
              cnt_d   = 8'h00;
              state_d = S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise && cnt_q != DUMMY_N) begin
            cnt_d = cnt_q + 8'd1;
          end else if (sck_fall && cnt_q == DUMMY_N) begin
            drive_hi = 1'b1;
            state_d  = S_DATA;
          end
        end
        S_DATA: begin
          if (sck_fall) begin
            if (lo_next_q) begin
              dout_d    = lo_q;
              lo_next_d = 1'b0;
            end else begin
              drive_hi = 1'b1;
            end
          end
        end
        S_IGNORE: begin
          oe_d = 4'h0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // high nibble goes out; low nibble is parked so the prefetch can
    // overwrite the byte register with the following address's data
    if (drive_hi) begin
      oe_d      = 4'hF;
      dout_d    = byte_q[7:4];
      lo_d      = byte_q[3:0];
      lo_next_d = 1'b1;
      addr_d    = addr_inc;
      maddr_d   = addr_inc[MEM_ADDR_BITS-1:0];
      rd_d      = 1'b1;
    end
  end

  assign spi_data_out = dout_q;
  assign spi_data_oe  = oe_q;
  assign mem_addr     = maddr_q;
  assign mem_rd       = rd_q;
  assign busy         = busy_q;
  assign cmd_error    = err_q;

endmodule
